// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port RAM between two requesters (m0, m1), round-robin or m0-first on ties.
// Latency: request sampled at edge E, RAM accessed in the cycle after E, ready pulses the cycle after that.
// Backpressure: requests are level-held until ready; at most one transaction per 3 cycles, nothing queued.
module mem_arbiter #(
  parameter int XLEN       = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            m0_req,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic [3:0]      m0_wmask,
  output logic            m0_ready,
  output logic [XLEN-1:0] m0_rdata,
  input  logic            m1_req,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic [3:0]      m1_wmask,
  output logic            m1_ready,
  output logic [XLEN-1:0] m1_rdata,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rstrb,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]      state_q;
  logic            g_q;        // granted requester of the transaction in flight (0 = m0, 1 = m1)
  logic            last_g_q;   // requester served most recently; resets to m1 so m0 wins the first tie
  logic            g_next;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      wmask_q;

  // Pick the requester to serve if a transaction starts this cycle
  always_comb begin
    g_next = 1'b0;
    if (m0_req && m1_req) begin
      g_next = FIXED_PRIO ? 1'b0 : ~last_g_q;
    end else begin
      g_next = m1_req;
    end
  end

  // Sequence IDLE -> ISSUE -> RESP and capture the granted request in IDLE only
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      g_q      <= 1'b0;
      last_g_q <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            g_q     <= g_next;
            addr_q  <= g_next ? m1_addr  : m0_addr;
            wdata_q <= g_next ? m1_wdata : m0_wdata;
            wmask_q <= g_next ? m1_wmask : m0_wmask;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          last_g_q <= g_q;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM port: address/data always show the latched request, strobes only during ISSUE
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = (state_q == ST_ISSUE) ? wmask_q : 4'b0000;
  assign mem_rstrb = (state_q == ST_ISSUE) && (wmask_q == 4'b0000);

  // Completion pulse to the granted requester; read data is a straight pass of the RAM output
  assign m0_ready = (state_q == ST_RESP) && !g_q;
  assign m1_ready = (state_q == ST_RESP) &&  g_q;
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance and a fixed-priority instance share the same requester stimulus.
// Each instance has its own RAM model; a transaction-level reference predicts grants, strobes and read data.
// Requesters hold req until the round-robin instance reports ready (the fixed instance sees the same inputs).
module tb_mem_arbiter;

  localparam int NW = 64;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;

  // index 0: round-robin instance, index 1: fixed-priority instance
  logic [1:0]       m0_ready, m1_ready, mem_rstrb;
  logic [1:0][31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0][3:0]  mem_wmask;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    mem_arbiter #(.XLEN(32), .FIXED_PRIO(i == 1)) u_dut (
      .clk(clk), .resetn(resetn),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
      .m0_ready(m0_ready[i]), .m0_rdata(m0_rdata[i]),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
      .m1_ready(m1_ready[i]), .m1_rdata(m1_rdata[i]),
      .mem_addr(mem_addr[i]), .mem_rstrb(mem_rstrb[i]), .mem_wdata(mem_wdata[i]),
      .mem_wmask(mem_wmask[i]), .mem_rdata(mem_rdata[i])
    );
  end

  // Single-port RAM models, one per instance: registered read, byte-masked write
  logic [31:0] ram [2][NW];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_rstrb[k]) mem_rdata[k] <= ram[k][mem_addr[k][7:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[k][b]) ram[k][mem_addr[k][7:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model state per instance (transaction level)
  int          busy [2];       // 0 free, 1 access on the RAM this cycle, 2 completion this cycle
  logic        last [2];       // requester served last
  logic        cur_g [2];
  logic [31:0] cur_addr [2], cur_wdata [2], exp_rd [2];
  logic [3:0]  cur_wmask [2];
  logic [31:0] refm [2][NW];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy[k] = 0; last[k] = 1'b1; cur_g[k] = 1'b0;
      cur_addr[k] = '0; cur_wdata[k] = '0; cur_wmask[k] = '0; exp_rd[k] = '0;
    end
  endtask

  // Advance the model over the coming clock edge using the inputs the DUT is about to sample
  task automatic model_pre();
    for (int k = 0; k < 2; k++) begin
      if (busy[k] == 0) begin
        if (m0_req || m1_req) begin
          if (m0_req && m1_req) cur_g[k] = (k == 1) ? 1'b0 : !last[k];
          else                  cur_g[k] = m1_req;
          cur_addr[k]  = cur_g[k] ? m1_addr  : m0_addr;
          cur_wdata[k] = cur_g[k] ? m1_wdata : m0_wdata;
          cur_wmask[k] = cur_g[k] ? m1_wmask : m0_wmask;
          busy[k] = 1;
        end
      end else if (busy[k] == 1) begin
        exp_rd[k] = refm[k][cur_addr[k][7:2]];
        for (int b = 0; b < 4; b++)
          if (cur_wmask[k][b]) refm[k][cur_addr[k][7:2]][8*b +: 8] = cur_wdata[k][8*b +: 8];
        busy[k] = 2;
      end else begin
        last[k] = cur_g[k];
        busy[k] = 0;
      end
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("i%0d_mem_addr", k),  mem_addr[k],  cur_addr[k]);
      check_eq($sformatf("i%0d_mem_wdata", k), mem_wdata[k], cur_wdata[k]);
      check_eq($sformatf("i%0d_mem_wmask", k), mem_wmask[k], (busy[k] == 1) ? cur_wmask[k] : 4'b0000);
      check_eq($sformatf("i%0d_mem_rstrb", k), mem_rstrb[k], (busy[k] == 1) && (cur_wmask[k] == 4'b0000));
      check_eq($sformatf("i%0d_m0_ready", k),  m0_ready[k],  (busy[k] == 2) && !cur_g[k]);
      check_eq($sformatf("i%0d_m1_ready", k),  m1_ready[k],  (busy[k] == 2) &&  cur_g[k]);
      if (busy[k] == 2 && cur_wmask[k] == 4'b0000)
        check_eq($sformatf("i%0d_rdata", k), cur_g[k] ? m1_rdata[k] : m0_rdata[k], exp_rd[k]);
    end
  endtask

  // One clock: predict, cross the edge, sample 1 time unit later
  task automatic step();
    model_pre();
    @(posedge clk);
    #1;
    model_check();
  endtask

  // Asynchronous reset asserted away from the edge; outputs must clear immediately
  task automatic do_reset();
    resetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_i%0d_m0_ready", k), m0_ready[k], 1'b0);
      check_eq($sformatf("rst_i%0d_m1_ready", k), m1_ready[k], 1'b0);
      check_eq($sformatf("rst_i%0d_rstrb", k), mem_rstrb[k], 1'b0);
      check_eq($sformatf("rst_i%0d_wmask", k), mem_wmask[k], 4'b0000);
      check_eq($sformatf("rst_i%0d_addr", k), mem_addr[k], 32'h0);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic new_txn(input int j);
    logic [31:0] a, d;
    logic [3:0]  m;
    a = {24'h0, 6'($urandom_range(0, NW - 1)), 2'b00};
    d = $urandom;
    m = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
    if (j == 0) begin m0_req = 1'b1; m0_addr = a; m0_wdata = d; m0_wmask = m; end
    else        begin m1_req = 1'b1; m1_addr = a; m1_wdata = d; m1_wmask = m; end
  endtask

  int grants[$];
  int fx_m0, fx_m1;

  initial begin
    m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
    m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < NW; w++) begin
        ram[k][w]  = 32'h5A00_0000 | 32'(w * 32'h0101);
        refm[k][w] = ram[k][w];
      end
      ram[k][4]  = 32'hDEAD_BEEF; refm[k][4]  = 32'hDEAD_BEEF;
      ram[k][8]  = 32'hAAAA_BBBB; refm[k][8]  = 32'hAAAA_BBBB;
      ram[k][12] = 32'h600D_0001; refm[k][12] = 32'h600D_0001;
      ram[k][13] = 32'h0BAD_0002; refm[k][13] = 32'h0BAD_0002;
    end
    model_reset();
    #2;
    do_reset();

    // m0 single read
    m0_req = 1'b1; m0_addr = 32'h10; m0_wmask = 4'b0000; m0_wdata = '0;
    step();
    check_eq("t1_rstrb", mem_rstrb[0], 1'b1);
    check_eq("t1_addr", mem_addr[0], 32'h10);
    step();
    check_eq("t1_ready", m0_ready[0], 1'b1);
    check_eq("t1_rdata", m0_rdata[0], 32'hDEAD_BEEF);
    check_eq("t1_m1_ready", m1_ready[0], 1'b0);
    m0_req = 1'b0;
    step();

    // m1 half-word write, then m0 readback
    m1_req = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1234_5678; m1_wmask = 4'b0011;
    step();
    check_eq("t2_wmask", mem_wmask[0], 4'b0011);
    check_eq("t2_rstrb", mem_rstrb[0], 1'b0);
    step();
    check_eq("t2_ready", m1_ready[0], 1'b1);
    m1_req = 1'b0;
    step();
    m0_req = 1'b1; m0_addr = 32'h20; m0_wmask = 4'b0000;
    step();
    step();
    check_eq("t2_readback", m0_rdata[0], 32'hAAAA_5678);
    m0_req = 1'b0;
    step();

    // address changed while the access is on the RAM
    m0_req = 1'b1; m0_addr = 32'h30; m0_wmask = 4'b0000;
    step();
    m0_addr = 32'h34;
    #1;
    check_eq("t6_addr_held", mem_addr[0], 32'h30);
    step();
    check_eq("t6_rdata", m0_rdata[0], 32'h600D_0001);
    m0_req = 1'b0;
    step();

    // both requesters held: alternation on instance 0, m0 only on instance 1
    do_reset();
    new_txn(0);
    new_txn(1);
    fx_m0 = 0; fx_m1 = 0;
    for (int c = 0; c < 40 && grants.size() < 6; c++) begin
      step();
      if (m1_ready[1]) fx_m1++;
      if (m0_ready[1]) fx_m0++;
      if (m0_ready[0]) begin grants.push_back(0); new_txn(0); end
      if (m1_ready[0]) begin grants.push_back(1); new_txn(1); end
    end
    check_eq("t3_grant_count", grants.size(), 6);
    foreach (grants[i]) check_eq($sformatf("t3_grant%0d", i), grants[i], i % 2);
    check_eq("t4_fixed_m1", fx_m1, 0);
    check_eq("t4_fixed_m0", fx_m0, 6);
    m0_req = 1'b0; m1_req = 1'b0;
    step(); step(); step();

    // reset in the middle of a write access
    m0_req = 1'b1; m0_addr = 32'h40; m0_wdata = 32'hCAFE_F00D; m0_wmask = 4'b1111;
    step();
    check_eq("t5_wmask_issue", mem_wmask[0], 4'b1111);
    new_txn(1);
    do_reset();
    step();
    step();
    check_eq("t5_first_m0_rr", m0_ready[0], 1'b1);
    check_eq("t5_first_m1_rr", m1_ready[0], 1'b0);
    check_eq("t5_first_m0_fx", m0_ready[1], 1'b1);

    // randomized traffic, including occasional early req drop and input changes while pending
    for (int c = 0; c < 1500; c++) begin
      step();
      for (int j = 0; j < 2; j++) begin
        logic r, rdy;
        r   = (j == 0) ? m0_req : m1_req;
        rdy = (j == 0) ? m0_ready[0] : m1_ready[0];
        if (r && rdy) begin
          if ($urandom_range(0, 3) != 0) new_txn(j);
          else if (j == 0) m0_req = 1'b0;
          else m1_req = 1'b0;
        end else if (!r) begin
          if ($urandom_range(0, 2) == 0) new_txn(j);
        end else if ($urandom_range(0, 19) == 0) begin
          if (j == 0) m0_req = 1'b0; else m1_req = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          new_txn(j);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
